chip8_audio_synth: RTL and testbench

//  Parametrised CHIP-8 tone generator: fixed-rate sample tick, phase-accumulator oscillator

---
 rtl/chip8_audio_pkg.sv | 21 ++
 rtl/chip8_audio_osc.sv | 63 ++++++
 rtl/chip8_audio_synth.sv | 137 +++++++++++++
 tb/tb_chip8_audio_synth.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_audio_pkg.sv
// Shared types and constants for the CHIP-8 tone generator: timbre encoding and noise LFSR.
package chip8_audio_pkg;

   typedef enum logic [1:0] {
      SQUARE = 2'd0,
      SAW    = 2'd1,
      TRI    = 2'd2,
      NOISE  = 2'd3
   } timbre_t;

   localparam int unsigned LFSR_W = 15;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
   // Taps for x^15 + x^14 + 1, bit indices of the shift register.
   localparam int unsigned LFSR_TAP_A = 14;
   localparam int unsigned LFSR_TAP_B = 13;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] i_state);
      return {i_state[LFSR_W-2:0], i_state[LFSR_TAP_A] ^ i_state[LFSR_TAP_B]};
   endfunction

endpackage

// File: rtl/chip8_audio_osc.sv
// Phase-accumulator oscillator with square/saw/triangle/noise timbres; emits a signed raw sample.
module chip8_audio_osc
   import chip8_audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned PHASE_W  = 24
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       tick_in,
   input  logic                       run_in,
   input  logic                       clear_in,
   input  timbre_t                    timbre_in,
   input  logic [PHASE_W-1:0]         pitch_in,
   output logic signed [SAMPLE_W-1:0] s_out
);

   localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic [PHASE_W-1:0]  r_phase;
   logic [PHASE_W-1:0]  w_phase_sum;
   logic                w_carry;
   logic [LFSR_W-1:0]   r_lfsr;
   logic [SAMPLE_W-1:0] w_p;
   logic [SAMPLE_W-1:0] w_tri_shl;
   logic [SAMPLE_W-1:0] w_tri_u;

   assign {w_carry, w_phase_sum} = {1'b0, r_phase} + {1'b0, pitch_in};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_phase <= '0;
         r_lfsr  <= LFSR_SEED;
      end else if (tick_in) begin
         if (clear_in) begin
            r_phase <= '0;
         end else if (run_in) begin
            r_phase <= w_phase_sum;
            // Noise advances once per oscillator period, so its rate follows pitch.
            if (w_carry) begin
               r_lfsr <= lfsr_next(r_lfsr);
            end
         end
      end
   end

   assign w_p       = r_phase[PHASE_W-1 -: SAMPLE_W];
   assign w_tri_shl = {w_p[SAMPLE_W-2:0], 1'b0};
   assign w_tri_u   = w_p[SAMPLE_W-1] ? ~w_tri_shl : w_tri_shl;

   // Subtracting the midpoint from an unsigned code is just an MSB flip.
   always_comb begin
      s_out = S_MIN;
      unique case (timbre_in)
         SQUARE: s_out = w_p[SAMPLE_W-1] ? S_MIN : S_MAX;
         SAW:    s_out = {~w_p[SAMPLE_W-1], w_p[SAMPLE_W-2:0]};
         TRI:    s_out = {~w_tri_u[SAMPLE_W-1], w_tri_u[SAMPLE_W-2:0]};
         NOISE:  s_out = r_lfsr[0] ? S_MAX : S_MIN;
      endcase
   end

endmodule

// File: rtl/chip8_audio_synth.sv
// CHIP-8 tone generator top: sample tick, config shadowing, gate, volume and output register.
// Define CHIP8_AUDIO_ENVELOPE_EN to replace the hard gate with a linear attack/release envelope.
module chip8_audio_synth
   import chip8_audio_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = 8,
   parameter int unsigned PHASE_W    = 24,
   parameter int unsigned VOL_W      = 4,
   parameter int unsigned SAMPLE_DIV = 2268
`ifdef CHIP8_AUDIO_ENVELOPE_EN
   ,
   parameter int unsigned ENV_W      = 8,
   parameter int unsigned ENV_RATE   = 1
`endif
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                active_in,
   input  logic                cfg_valid_in,
   input  logic [1:0]          timbre_in,
   input  logic [PHASE_W-1:0]  pitch_in,
   input  logic [VOL_W-1:0]    vol_in,
   output logic                sample_tick_out,
   output logic [SAMPLE_W-1:0] level_out
);

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic [CNT_W-1:0]            r_cnt;
   logic                        w_tick;
   timbre_t                     r_timbre;
   logic [PHASE_W-1:0]          r_pitch;
   logic [VOL_W-1:0]            r_vol;
   logic                        w_run;
   logic                        w_clear;
   logic signed [SAMPLE_W-1:0]  w_s;
   logic signed [SAMPLE_W+VOL_W:0] w_prod;
   logic signed [SAMPLE_W-1:0]  w_g;
   logic [SAMPLE_W-1:0]         w_level_d;
   logic [SAMPLE_W-1:0]         r_level;

   assign w_tick          = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
   assign sample_tick_out = w_tick;
   assign level_out       = r_level;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // The tick consumes the shadow value present before its edge, so a write landing on the
   // tick cycle is first heard on the following tick.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_timbre <= SQUARE;
         r_pitch  <= '0;
         r_vol    <= '0;
      end else if (cfg_valid_in) begin
         r_timbre <= timbre_t'(timbre_in);
         r_pitch  <= pitch_in;
         r_vol    <= vol_in;
      end
   end

   chip8_audio_osc #(
      .SAMPLE_W (SAMPLE_W),
      .PHASE_W  (PHASE_W)
   ) u_osc (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .tick_in   (w_tick),
      .run_in    (w_run),
      .clear_in  (w_clear),
      .timbre_in (r_timbre),
      .pitch_in  (r_pitch),
      .s_out     (w_s)
   );

   assign w_prod = w_s * $signed({1'b0, r_vol});
   assign w_g    = SAMPLE_W'(w_prod >>> VOL_W);

`ifdef CHIP8_AUDIO_ENVELOPE_EN
   localparam logic [ENV_W:0] ENV_MAX  = {1'b0, {ENV_W{1'b1}}};
   localparam logic [ENV_W:0] ENV_STEP = (ENV_W + 1)'(ENV_RATE);

   logic [ENV_W-1:0]                r_env;
   logic [ENV_W-1:0]                w_env_d;
   logic [ENV_W:0]                  w_env_sum;
   logic signed [SAMPLE_W+ENV_W:0]  w_env_prod;
   logic signed [SAMPLE_W-1:0]      w_out_g;

   assign w_env_sum = {1'b0, r_env} + ENV_STEP;

   always_comb begin
      w_env_d = r_env;
      if (active_in) begin
         w_env_d = (w_env_sum > ENV_MAX) ? ENV_W'(ENV_MAX) : w_env_sum[ENV_W-1:0];
      end else begin
         w_env_d = ({1'b0, r_env} > ENV_STEP) ? ENV_W'({1'b0, r_env} - ENV_STEP) : '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_env <= '0;
      end else if (w_tick) begin
         r_env <= w_env_d;
      end
   end

   // The tick's sample is scaled by the envelope value it is stepping to.
   assign w_run      = (w_env_d != '0);
   assign w_clear    = !active_in && (w_env_d == '0);
   assign w_env_prod = w_g * $signed({1'b0, w_env_d});
   assign w_out_g    = SAMPLE_W'(w_env_prod >>> ENV_W);
   assign w_level_d  = {~w_out_g[SAMPLE_W-1], w_out_g[SAMPLE_W-2:0]};
`else
   assign w_run     = active_in;
   assign w_clear   = !active_in;
   assign w_level_d = active_in ? {~w_g[SAMPLE_W-1], w_g[SAMPLE_W-2:0]} : MID;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_level <= MID;
      end else if (w_tick) begin
         r_level <= w_level_d;
      end
   end

endmodule

// File: tb/tb_chip8_audio_synth.sv
// Directed bench for chip8_audio_synth at SAMPLE_W=8, PHASE_W=8, VOL_W=4, SAMPLE_DIV=4.
module tb_chip8_audio_synth;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       active;
   logic       cfg_valid;
   logic [1:0] timbre;
   logic [7:0] pitch;
   logic [3:0] vol;
   logic       tick;
   logic [7:0] level;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   chip8_audio_synth #(
      .SAMPLE_W   (8),
      .PHASE_W    (8),
      .VOL_W      (4),
      .SAMPLE_DIV (4)
   ) dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .active_in       (active),
      .cfg_valid_in    (cfg_valid),
      .timbre_in       (timbre),
      .pitch_in        (pitch),
      .vol_in          (vol),
      .sample_tick_out (tick),
      .level_out       (level)
   );

   // Waits for the next tick pulse and returns level_out one cycle later (counter back at 0).
   task automatic sample_next(output logic [7:0] lvl);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tick) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL tick_timeout: sample_tick_out=%b, required a pulse within 8 cycles", tick);
      end
      @(negedge clk);
      lvl = level;
   endtask

   task automatic set_cfg(input logic [1:0] t, input logic [7:0] p, input logic [3:0] v);
      cfg_valid = 1'b1;
      timbre    = t;
      pitch     = p;
      vol       = v;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Close the gate for one tick (phase back to 0), load config, reopen.
   task automatic restart(input logic [1:0] t, input logic [7:0] p, input logic [3:0] v);
      logic [7:0] dummy;
      active = 1'b0;
      sample_next(dummy);
      set_cfg(t, p, v);
      active = 1'b1;
   endtask

   task automatic test_reset();
      int last;
      int n_ticks;
      int first;
      rst_n = 1'b0;
      #12;
      n_tests++;
      if (level !== 8'h80) begin
         n_fail++;
         $display("FAIL reset_level: got %h, required 80", level);
      end
      n_tests++;
      if (tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tick: got %b, required 0", tick);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      last    = -1;
      first   = -1;
      n_ticks = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (tick === 1'b1) begin
            if (first < 0) first = i;
            if (last >= 0) begin
               n_tests++;
               if (i - last !== 4) begin
                  n_fail++;
                  $display("FAIL tick_period: got %0d, required 4", i - last);
               end
            end
            last = i;
            n_ticks++;
         end
      end
      n_tests++;
      if (first !== 2) begin
         n_fail++;
         $display("FAIL tick_first: got cycle %0d, required 2", first);
      end
      n_tests++;
      if (n_ticks !== 3) begin
         n_fail++;
         $display("FAIL tick_count: got %0d, required 3", n_ticks);
      end
      n_tests++;
      if (level !== 8'h80) begin
         n_fail++;
         $display("FAIL idle_level: got %h, required 80", level);
      end
   endtask

   task automatic test_square();
      logic [7:0] exp_seq [4] = '{8'hF7, 8'hF7, 8'h08, 8'h08};
      logic [7:0] got;
      restart(2'd0, 8'h40, 4'd15);
      for (int i = 0; i < 8; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== exp_seq[i % 4]) begin
            n_fail++;
            $display("FAIL square[%0d]: got %h, required %h", i, got, exp_seq[i % 4]);
         end
      end
   endtask

   task automatic test_saw();
      logic [7:0] exp_seq [4] = '{8'h08, 8'h44, 8'h80, 8'hBC};
      logic [7:0] got;
      restart(2'd1, 8'h40, 4'd15);
      for (int i = 0; i < 8; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== exp_seq[i % 4]) begin
            n_fail++;
            $display("FAIL saw[%0d]: got %h, required %h", i, got, exp_seq[i % 4]);
         end
      end
      set_cfg(2'd1, 8'h40, 4'd0);
      for (int i = 0; i < 4; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== 8'h80) begin
            n_fail++;
            $display("FAIL saw_vol0[%0d]: got %h, required 80", i, got);
         end
      end
   endtask

   task automatic test_cfg_on_tick();
      logic [7:0] exp_seq [3] = '{8'h08, 8'h08, 8'hF7};
      logic [7:0] got;
      bit seen;
      restart(2'd1, 8'h40, 4'd15);
      sample_next(got);
      n_tests++;
      if (got !== 8'h08) begin
         n_fail++;
         $display("FAIL cfg_tick_first: got %h, required 08", got);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tick) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL cfg_tick_wait: sample_tick_out=%b, required 1", tick);
      end
      cfg_valid = 1'b1;
      timbre    = 2'd0;
      pitch     = 8'h40;
      vol       = 4'd15;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_tests++;
      if (level !== 8'h44) begin
         n_fail++;
         $display("FAIL cfg_tick_old: got %h, required 44", level);
      end
      for (int i = 0; i < 3; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL cfg_tick_new[%0d]: got %h, required %h", i, got, exp_seq[i]);
         end
      end
   endtask

   task automatic test_noise();
      logic [14:0] m_lfsr;
      logic [7:0]  m_phase;
      logic [8:0]  m_sum;
      logic [7:0]  m_pitch;
      logic [7:0]  exp_lvl;
      logic [7:0]  got;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      m_lfsr  = 15'h0001;
      m_phase = 8'h00;
      restart(2'd3, 8'h80, 4'd15);
      for (int i = 0; i < 58; i++) begin
         if (i == 40) set_cfg(2'd3, 8'h00, 4'd15);
         if (i == 46) set_cfg(2'd3, 8'h80, 4'd15);
         m_pitch = (i >= 40 && i < 46) ? 8'h00 : 8'h80;
         sample_next(got);
         exp_lvl = m_lfsr[0] ? 8'hF7 : 8'h08;
         n_tests++;
         if (got !== exp_lvl) begin
            n_fail++;
            $display("FAIL noise[%0d]: got %h, required %h", i, got, exp_lvl);
         end
         m_sum   = {1'b0, m_phase} + {1'b0, m_pitch};
         m_phase = m_sum[7:0];
         if (m_sum[8]) m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
      end
   endtask

   task automatic test_gate();
      logic [7:0] exp_seq [3] = '{8'hF7, 8'hF7, 8'h08};
      logic [7:0] got;
      restart(2'd0, 8'h40, 4'd15);
      for (int i = 0; i < 2; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== 8'hF7) begin
            n_fail++;
            $display("FAIL gate_open[%0d]: got %h, required F7", i, got);
         end
      end
      active = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== 8'h80) begin
            n_fail++;
            $display("FAIL gate_closed[%0d]: got %h, required 80", i, got);
         end
      end
      active = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample_next(got);
         n_tests++;
         if (got !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL gate_reopen[%0d]: got %h, required %h", i, got, exp_seq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] got;
      sample_next(got);
      n_tests++;
      if (got !== 8'h08) begin
         n_fail++;
         $display("FAIL pre_reset_tone: got %h, required 08", got);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (level !== 8'h80) begin
         n_fail++;
         $display("FAIL async_reset_level: got %h, required 80", level);
      end
      n_tests++;
      if (tick !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_tick: got %b, required 0", tick);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      active    = 1'b0;
      cfg_valid = 1'b0;
      timbre    = 2'd0;
      pitch     = 8'h00;
      vol       = 4'd0;
      test_reset();
      test_square();
      test_saw();
      test_cfg_on_tick();
      test_noise();
      test_gate();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
